insfetch: RTL and testbench

//  Instruction prefetch queue for the Tom GPU/DSP core; supplier end of the insrdy/romold handshake that execution control consumes.

---
 rtl/insfetch_pkg.sv | 28 ++
 rtl/insfetch_if.sv | 34 +++
 rtl/insfetch_insq.sv | 115 +++++++++++
 rtl/insfetch.sv | 157 +++++++++++++++
 tb/tb_insfetch.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/insfetch_pkg.sv
// -----------------------------------------------------------------------------
// insfetch_pkg
// Shared definitions for the instruction prefetch block:
//   PCW_DEF   default program-counter width (byte address)
//   INSW      opcode / immediate word width
//   HI_FIRST  halfword select: take [31:16] (lower address) first
//   LO_FIRST  halfword select: take [15:0] only (odd-halfword entry point)
//   fetch_state_t  fetch FSM state encoding
// -----------------------------------------------------------------------------
package insfetch_pkg;

   localparam int   PCW_DEF  = 24;
   localparam int   INSW     = 16;
   localparam logic HI_FIRST = 1'b0;
   localparam logic LO_FIRST = 1'b1;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_REQ  = 1'b1
   } fetch_state_t;

   // Longs are big-endian: [31:16] lives at the lower halfword address.
   function automatic logic [INSW-1:0] pick_half(input logic [31:0] long_w,
                                                 input logic        sel);
      return (sel == LO_FIRST) ? long_w[15:0] : long_w[31:16];
   endfunction

endpackage

// File: rtl/insfetch_if.sv
// -----------------------------------------------------------------------------
// insfetch_if
// Bus bundle of the prefetch queue: the program-RAM read port
// (fetch_req/fetch_addr/fetch_ack/fetch_data) and the execution-control
// handshake (insrdy/instr/instpc/romold).
//   master : the prefetch queue (drives req/addr and the instruction word)
//   slave  : memory plus execution control (drives ack/data and romold)
// -----------------------------------------------------------------------------
interface insfetch_if
   import insfetch_pkg::*;
#(
   parameter int PCW = PCW_DEF
);

   logic            fetch_req;
   logic [PCW-3:0]  fetch_addr;
   logic            fetch_ack;
   logic [31:0]     fetch_data;
   logic            insrdy;
   logic [INSW-1:0] instr;
   logic [PCW-1:0]  instpc;
   logic            romold;

   modport master (
      output fetch_req, fetch_addr, insrdy, instr, instpc,
      input  fetch_ack, fetch_data, romold
   );

   modport slave (
      input  fetch_req, fetch_addr, insrdy, instr, instpc,
      output fetch_ack, fetch_data, romold
   );

endinterface

// File: rtl/insfetch_insq.sv
// -----------------------------------------------------------------------------
// insq
// QDEPTH x 16 circular FIFO with a 2-word push port and a 1-word pop port.
// The head word and its valid flag are registered from the post-update queue
// state, so a word pushed into an empty queue is visible the next cycle.
// Ports:
//   clk_0, reset_n    clock, asynchronous active-low reset
//   i_flush           empty the queue (dominates push/pop)
//   i_push, i_two     push i_w0, and i_w1 after it when i_two=1
//   i_w0, i_w1        words to push (i_w0 is the earlier address)
//   i_pop             remove the head word (ignored when empty)
//   o_free            free slots
//   o_vld, o_head     registered head-of-queue valid and word
// -----------------------------------------------------------------------------
module insq
   import insfetch_pkg::*;
#(
   parameter  int QDEPTH = 4,
   localparam int PW     = $clog2(QDEPTH),
   localparam int CW     = PW + 1
) (
   input  logic            clk_0,
   input  logic            reset_n,
   input  logic            i_flush,
   input  logic            i_push,
   input  logic            i_two,
   input  logic [INSW-1:0] i_w0,
   input  logic [INSW-1:0] i_w1,
   input  logic            i_pop,
   output logic [CW-1:0]   o_free,
   output logic            o_vld,
   output logic [INSW-1:0] o_head
);

   logic [INSW-1:0] r_mem [QDEPTH];
   logic [PW-1:0]   r_rd;
   logic [PW-1:0]   r_wr;
   logic [CW-1:0]   r_count;
   logic            r_vld;
   logic [INSW-1:0] r_head;

   logic            w_pop;
   logic            w_wr_en;
   logic [CW-1:0]   w_npush;
   logic [CW-1:0]   w_cnt_mid;
   logic [CW-1:0]   w_cnt_nxt;
   logic [PW-1:0]   w_rd_nxt;
   logic [PW-1:0]   w_wr_nxt;
   logic [PW-1:0]   w_wr_2nd;
   logic [INSW-1:0] w_head_nxt;

   always_comb begin
      w_pop     = i_pop & (r_count != '0);
      w_wr_en   = i_push & ~i_flush;
      w_npush   = '0;
      if (w_wr_en) begin
         w_npush = i_two ? CW'(2) : CW'(1);
      end
      w_rd_nxt  = r_rd + PW'(w_pop);
      w_cnt_mid = r_count - CW'(w_pop);
      w_cnt_nxt = w_cnt_mid + w_npush;
      // Pointers are PW bits and wrap modulo QDEPTH on their own.
      w_wr_nxt  = r_wr + w_npush[PW-1:0];
      w_wr_2nd  = r_wr + PW'(1);
      // If the pop leaves nothing behind, the new head is the first word
      // being pushed this cycle (bypass around the storage array).
      w_head_nxt = (w_cnt_mid != '0) ? r_mem[w_rd_nxt] : i_w0;
   end

   always_ff @(posedge clk_0 or negedge reset_n) begin
      if (!reset_n) begin
         r_rd    <= '0;
         r_wr    <= '0;
         r_count <= '0;
         r_vld   <= 1'b0;
         r_head  <= '0;
      end else if (i_flush) begin
         r_rd    <= '0;
         r_wr    <= '0;
         r_count <= '0;
         r_vld   <= 1'b0;
      end else begin
         r_rd    <= w_rd_nxt;
         r_wr    <= w_wr_nxt;
         r_count <= w_cnt_nxt;
         r_vld   <= (w_cnt_nxt != '0);
         r_head  <= w_head_nxt;
      end
   end

   always_ff @(posedge clk_0) begin
      if (w_wr_en) begin
         r_mem[r_wr] <= i_w0;
         if (i_two) begin
            r_mem[w_wr_2nd] <= i_w1;
         end
      end
   end

`ifndef SYNTHESIS
   // The fetcher only requests with two free slots, so this never fires
   // unless the issue logic is broken.
   always_ff @(posedge clk_0) begin
      if (reset_n && !i_flush) begin
         assert ((int'(w_cnt_mid) + int'(w_npush)) <= QDEPTH)
            else $error("insq overflow: count=%0d push=%0d", w_cnt_mid, w_npush);
      end
   end
`endif

   assign o_free = CW'(QDEPTH) - r_count;
   assign o_vld  = r_vld;
   assign o_head = r_head;

endmodule

// File: rtl/insfetch.sv
// -----------------------------------------------------------------------------
// insfetch
// Instruction prefetch queue. Reads big-endian 32-bit longs from program RAM
// through a single-outstanding req/ack port, splits them into 16-bit words and
// presents them in address order to execution control with insrdy/romold.
// A PC load flushes the queue and restarts fetching at the new address.
// Ports:
//   clk_0    core clock
//   reset_n  asynchronous active-low reset
//   go       core running; 0 stops issuing new fetches
//   pcload   load pcnew and flush the queue
//   pcnew    new PC (byte address); bit 1 set starts on the low halfword
//   bus      insfetch_if.master: fetch_req/fetch_addr/fetch_ack/fetch_data,
//            insrdy/instr/instpc/romold
// -----------------------------------------------------------------------------
module insfetch
   import insfetch_pkg::*;
#(
   parameter int QDEPTH = 4,
   parameter int PCW    = PCW_DEF
) (
   input  logic           clk_0,
   input  logic           reset_n,
   input  logic           go,
   input  logic           pcload,
   input  logic [PCW-1:0] pcnew,
   insfetch_if.master     bus
);

   localparam int CW = $clog2(QDEPTH) + 1;

   fetch_state_t    r_state;
   fetch_state_t    w_state_nxt;
   logic [PCW-3:0]  r_fetch_addr;
   logic [PCW-3:0]  w_addr_nxt;
   logic [PCW-3:0]  r_pend_addr;
   logic [PCW-3:0]  w_pend_nxt;
   logic [PCW-1:0]  r_instpc;
   logic [PCW-1:0]  w_pc_nxt;
   logic            r_discard;
   logic            w_discard_nxt;
   logic            r_skip;
   logic            w_skip_nxt;

   logic            w_ack;
   logic            w_push;
   logic            w_two;
   logic            w_pop;
   logic            w_flush;
   logic [INSW-1:0] w_w0;
   logic [CW-1:0]   w_free;
   logic            w_vld;
   logic [INSW-1:0] w_head;

   assign w_ack = (r_state == S_REQ) & bus.fetch_ack;
   assign w_w0  = pick_half(bus.fetch_data, r_skip ? LO_FIRST : HI_FIRST);

   always_ff @(posedge clk_0 or negedge reset_n) begin
      if (!reset_n) begin
         r_state      <= S_IDLE;
         r_fetch_addr <= '0;
         r_pend_addr  <= '0;
         r_instpc     <= '0;
         r_discard    <= 1'b0;
         r_skip       <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_fetch_addr <= w_addr_nxt;
         r_pend_addr  <= w_pend_nxt;
         r_instpc     <= w_pc_nxt;
         r_discard    <= w_discard_nxt;
         r_skip       <= w_skip_nxt;
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_addr_nxt    = r_fetch_addr;
      w_pend_nxt    = r_pend_addr;
      w_pc_nxt      = r_instpc;
      w_discard_nxt = r_discard;
      w_skip_nxt    = r_skip;
      w_push        = 1'b0;
      w_two         = 1'b0;
      w_pop         = 1'b0;
      w_flush       = 1'b0;

      if (pcload) begin
         // A PC load overrides any pop and any push in the same cycle.
         w_flush    = 1'b1;
         w_pc_nxt   = pcnew & ~PCW'(1);
         w_skip_nxt = pcnew[1];
         if ((r_state == S_REQ) && !bus.fetch_ack) begin
            // The request must still finish on the bus; its data belongs to
            // the old stream, so drop it and park the new address until then.
            w_discard_nxt = 1'b1;
            w_pend_nxt    = pcnew[PCW-1:2];
         end else begin
            // Idle, or the outstanding request is acked right now and its
            // data is dropped here, so nothing is left to discard later.
            w_state_nxt   = S_IDLE;
            w_addr_nxt    = pcnew[PCW-1:2];
            w_discard_nxt = 1'b0;
         end
      end else begin
         w_pop = bus.romold & w_vld;
         if (w_pop) begin
            w_pc_nxt = r_instpc + PCW'(2);
         end
         unique case (r_state)
            S_IDLE: begin
               if (go && (w_free >= CW'(2))) begin
                  w_state_nxt = S_REQ;
               end
            end
            S_REQ: begin
               if (w_ack) begin
                  w_state_nxt = S_IDLE;
                  if (r_discard) begin
                     w_addr_nxt    = r_pend_addr;
                     w_discard_nxt = 1'b0;
                  end else begin
                     w_addr_nxt = r_fetch_addr + (PCW-2)'(1);
                     w_push     = 1'b1;
                     w_two      = ~r_skip;
                     w_skip_nxt = 1'b0;
                  end
               end
            end
            default: w_state_nxt = S_IDLE;
         endcase
      end
   end

   insq #(
      .QDEPTH (QDEPTH)
   ) u_insq (
      .clk_0   (clk_0),
      .reset_n (reset_n),
      .i_flush (w_flush),
      .i_push  (w_push),
      .i_two   (w_two),
      .i_w0    (w_w0),
      .i_w1    (bus.fetch_data[15:0]),
      .i_pop   (w_pop),
      .o_free  (w_free),
      .o_vld   (w_vld),
      .o_head  (w_head)
   );

   assign bus.fetch_req  = (r_state == S_REQ);
   assign bus.fetch_addr = r_fetch_addr;
   assign bus.insrdy     = w_vld;
   assign bus.instr      = w_head;
   assign bus.instpc     = r_instpc;

endmodule

// File: tb/tb_insfetch.sv
// -----------------------------------------------------------------------------
// tb_insfetch
// Bench for insfetch (QDEPTH=4, PCW=24). A program-RAM responder answers
// fetch requests after a configurable latency; the instruction stream is
// checked against the rule "instr at instpc is the big-endian halfword of
// memory at byte address instpc".
// -----------------------------------------------------------------------------
module tb_insfetch;
   import insfetch_pkg::*;

   localparam int PCW  = 24;
   localparam int MASK = 32'h00FF_FFFF;

   logic           clk_0 = 1'b0;
   logic           reset_n;
   logic           go;
   logic           pcload;
   logic [PCW-1:0] pcnew;

   insfetch_if #(.PCW(PCW)) bus ();

   insfetch #(.QDEPTH(4), .PCW(PCW)) dut (
      .clk_0   (clk_0),
      .reset_n (reset_n),
      .go      (go),
      .pcload  (pcload),
      .pcnew   (pcnew),
      .bus     (bus)
   );

   always #5 clk_0 = ~clk_0;

   int          total = 0;
   int          bad   = 0;
   logic [31:0] mem_ovr [int];
   int          acks[$];
   int          lat  = 0;
   int          wcnt = 0;

   function automatic logic [31:0] mem_rd(input int a);
      logic [15:0] k;
      k = a[15:0];
      if (mem_ovr.exists(a)) return mem_ovr[a];
      return {k ^ 16'hC3A5, k + 16'h1111};
   endfunction

   function automatic logic [15:0] hw(input int b);
      logic [31:0] l;
      int          bb;
      bb = b & MASK;
      l  = mem_rd(bb >> 2);
      return bb[1] ? l[15:0] : l[31:16];
   endfunction

   // Program RAM: acks on a falling edge so the DUT samples it on the next rise.
   initial begin
      bus.fetch_ack  = 1'b0;
      bus.fetch_data = '0;
      forever begin
         @(negedge clk_0);
         if (!reset_n) begin
            bus.fetch_ack = 1'b0;
            wcnt = 0;
         end else if (bus.fetch_ack) begin
            bus.fetch_ack = 1'b0;
            wcnt = 0;
         end else if (bus.fetch_req) begin
            if (wcnt >= lat) begin
               bus.fetch_ack  = 1'b1;
               bus.fetch_data = mem_rd(int'(bus.fetch_addr));
               acks.push_back(int'(bus.fetch_addr));
            end else begin
               wcnt++;
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk_0);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
         else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
         end
   endtask

   task automatic wait_req(input string tag);
      int n = 0;
      while (!bus.fetch_req && n < 40) begin
         tick();
         n++;
      end
      chk({tag, " req timeout"}, 32'(bus.fetch_req), 32'd1);
   endtask

   task automatic wait_rdy(input string tag);
      int n = 0;
      while (!bus.insrdy && n < 40) begin
         tick();
         n++;
      end
      chk({tag, " rdy timeout"}, 32'(bus.insrdy), 32'd1);
   endtask

   task automatic go_idle();
      int n = 0;
      go = 1'b0;
      bus.romold = 1'b0;
      while (bus.fetch_req && n < 40) begin
         tick();
         n++;
      end
      chk("idle timeout", 32'(bus.fetch_req), 32'd0);
      tick();
      acks.delete();
   endtask

   task automatic do_pcload(input int addr);
      pcload = 1'b1;
      pcnew  = PCW'(addr);
      tick();
      pcload = 1'b0;
   endtask

   int          n0;
   int          exp_pc;
   logic        rdy;
   logic        pl;

   initial begin
      reset_n    = 1'b0;
      go         = 1'b0;
      pcload     = 1'b0;
      pcnew      = '0;
      bus.romold = 1'b0;
      repeat (3) tick();

      // Reset state
      chk("rst fetch_req",  32'(bus.fetch_req),  32'd0);
      chk("rst fetch_addr", 32'(bus.fetch_addr), 32'd0);
      chk("rst insrdy",     32'(bus.insrdy),     32'd0);
      chk("rst instr",      32'(bus.instr),      32'd0);
      chk("rst instpc",     32'(bus.instpc),     32'd0);
      reset_n = 1'b1;
      tick();

      // 1: aligned start, hi then lo halfword
      mem_ovr[32'h40] = 32'h9876_1234;
      go = 1'b1;
      do_pcload(32'h100);
      chk("t1 instpc after load", 32'(bus.instpc), 32'h100);
      chk("t1 insrdy after load", 32'(bus.insrdy), 32'd0);
      wait_req("t1");
      chk("t1 fetch_addr", 32'(bus.fetch_addr), 32'h40);
      wait_rdy("t1");
      chk("t1 instr0", 32'(bus.instr),  32'h9876);
      chk("t1 pc0",    32'(bus.instpc), 32'h100);
      bus.romold = 1'b1;
      tick();
      bus.romold = 1'b0;
      chk("t1 instr1", 32'(bus.instr),  32'h1234);
      chk("t1 pc1",    32'(bus.instpc), 32'h102);

      // 2: odd-halfword start drops the high half
      go_idle();
      mem_ovr[32'h40] = 32'hAAAA_5555;
      go = 1'b1;
      do_pcload(32'h102);
      wait_rdy("t2");
      chk("t2 instr", 32'(bus.instr),  32'h5555);
      chk("t2 pc",    32'(bus.instpc), 32'h102);
      repeat (4) tick();
      chk("t2 ack count", 32'(acks.size() >= 2), 32'd1);
      chk("t2 addr0", 32'(acks[0]), 32'h40);
      chk("t2 addr1", 32'(acks[1]), 32'h41);
      bus.romold = 1'b1;
      tick();
      bus.romold = 1'b0;
      chk("t2 instr next", 32'(bus.instr),  32'(hw(32'h104)));
      chk("t2 pc next",    32'(bus.instpc), 32'h104);

      // 3: queue fills, issue stops, two pops free room for one more long
      go_idle();
      go = 1'b1;
      do_pcload(32'h300);
      repeat (30) tick();
      chk("t3 longs fetched", 32'(acks.size()), 32'd2);
      chk("t3 req held off",  32'(bus.fetch_req), 32'd0);
      chk("t3 instr head",    32'(bus.instr), 32'(hw(32'h300)));
      bus.romold = 1'b1;
      tick();
      tick();
      bus.romold = 1'b0;
      chk("t3 pc after pops",    32'(bus.instpc), 32'h304);
      chk("t3 instr after pops", 32'(bus.instr),  32'(hw(32'h304)));
      repeat (10) tick();
      chk("t3 third fetch", 32'(acks.size()), 32'd3);

      // 4: pcload while a slow request is outstanding
      go_idle();
      lat = 3;
      go = 1'b1;
      do_pcload(32'h500);
      wait_req("t4");
      tick();
      n0 = acks.size();
      do_pcload(32'h200);
      chk("t4 insrdy after load", 32'(bus.insrdy), 32'd0);
      chk("t4 req still up",      32'(bus.fetch_req), 32'd1);
      begin
         int n = 0;
         while (acks.size() == n0 && n < 20) begin
            tick();
            n++;
         end
      end
      chk("t4 stale ack seen", 32'(acks.size()), 32'(n0 + 1));
      chk("t4 stale dropped",  32'(bus.insrdy), 32'd0);
      tick();
      chk("t4 still empty", 32'(bus.insrdy), 32'd0);
      wait_req("t4b");
      chk("t4 new fetch_addr", 32'(bus.fetch_addr), 32'h80);
      wait_rdy("t4");
      chk("t4 instr", 32'(bus.instr),  32'(hw(32'h200)));
      chk("t4 pc",    32'(bus.instpc), 32'h200);
      lat = 0;

      // 5: pcload coinciding with fetch_ack and romold
      go_idle();
      go = 1'b1;
      do_pcload(32'h700);
      begin
         int n = 0;
         while (!(bus.fetch_req && bus.insrdy) && n < 40) begin
            tick();
            n++;
         end
      end
      chk("t5 setup", 32'(bus.fetch_req & bus.insrdy), 32'd1);
      n0 = acks.size();
      bus.romold = 1'b1;
      do_pcload(32'h600);
      bus.romold = 1'b0;
      chk("t5 ack in load cycle", 32'(acks.size()), 32'(n0 + 1));
      chk("t5 insrdy", 32'(bus.insrdy), 32'd0);
      chk("t5 instpc", 32'(bus.instpc), 32'h600);
      wait_req("t5");
      chk("t5 fetch_addr", 32'(bus.fetch_addr), 32'h180);
      wait_rdy("t5");
      chk("t5 instr", 32'(bus.instr),  32'(hw(32'h600)));
      chk("t5 pc",    32'(bus.instpc), 32'h600);

      // 6: back-to-back loads (last wins), wrap, then random pops/loads/latency
      go_idle();
      go = 1'b1;
      pcload = 1'b1;
      pcnew  = PCW'(32'h000900);
      tick();
      pcnew  = PCW'(32'hFFFFFA);
      tick();
      pcload = 1'b0;
      exp_pc = 32'hFFFFFA;
      for (int i = 0; i < 600; i++) begin
         chk("t6 instpc", 32'(bus.instpc), 32'(exp_pc));
         if (bus.insrdy) chk("t6 instr", 32'(bus.instr), 32'(hw(exp_pc)));
         rdy = bus.insrdy;
         bus.romold = (i < 40) ? 1'b1 : ($urandom_range(0, 3) != 0);
         pl = (i >= 40) && ($urandom_range(0, 31) == 0);
         pcload = pl;
         if (pl) pcnew = PCW'($urandom);
         lat = (i < 300) ? 0 : int'($urandom_range(0, 3));
         tick();
         if (pl) exp_pc = int'(pcnew) & ~1;
         else if (bus.romold && rdy) exp_pc = (exp_pc + 2) & MASK;
      end
      pcload = 1'b0;
      bus.romold = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
